// File: rtl/udp_multi_seq_pkg.sv
// Shared definitions for the multi-channel UDP frame sequencer.
package udp_multi_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_ACQ_START,
    ST_ACQ_WAIT,
    ST_PKT_START,
    ST_PKT_WAIT,
    ST_TX_START,
    ST_TX_WAIT
  } seq_state_e;

  localparam int DEF_PERIOD  = 50000000;
  localparam int DEF_TIMEOUT = 1000000;
  localparam int FRAME_CNT_W = 16;
  localparam int ERR_CNT_W   = 8;

  // Error counter saturates instead of wrapping so a stuck link stays visible.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/udp_tick_gen.sv
// Frame tick generator: one-cycle tick every P_PERIOD clocks while enabled.
module udp_tick_gen #(
  parameter int P_PERIOD = 50000000
) (
  input  logic clk,
  input  logic a_rst_i,
  input  logic i_en,
  output logic o_tick
);
  localparam int CW = $clog2(P_PERIOD);

  logic [CW-1:0] cnt;

  // Count 0..P_PERIOD-1 while enabled; disabled holds the phase at zero.
  always_ff @(posedge clk or posedge a_rst_i) begin
    if (a_rst_i) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (!i_en) begin
      cnt    <= '0;
      o_tick <= 1'b0;
    end else if (cnt == CW'(P_PERIOD - 1)) begin
      cnt    <= '0;
      o_tick <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      o_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/udp_multi_seq.sv
// Periodic frame sequencer: acquire enabled channels, build packet, transmit.
module udp_multi_seq
  import udp_multi_seq_pkg::*;
#(
  parameter int N_CH      = 4,
  parameter int P_PERIOD  = DEF_PERIOD,
  parameter int P_TIMEOUT = DEF_TIMEOUT,
  parameter int CHW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   a_rst_i,
  input  logic                   i_ready,
  input  logic [N_CH-1:0]        i_ch_en,
  output logic                   o_acq_start,
  output logic [CHW-1:0]         o_acq_ch,
  input  logic                   i_acq_end,
  output logic                   o_pkt_start,
  input  logic                   i_pkt_end,
  output logic                   o_tx_start,
  input  logic                   i_tx_end,
  output logic                   o_busy,
  output logic                   o_timeout,
  output logic                   o_overrun,
  output logic [FRAME_CNT_W-1:0] o_frame_cnt,
  output logic [ERR_CNT_W-1:0]   o_err_cnt
);
  localparam int TW = $clog2(P_TIMEOUT + 1);

  seq_state_e     state;
  logic [N_CH-1:0] mask;
  logic [TW-1:0]  phase_cnt;
  logic           tick;
  logic           first_ok, nxt_ok, expired;
  logic [CHW-1:0] first_ch, nxt_ch;

  udp_tick_gen #(.P_PERIOD(P_PERIOD)) u_tick (
    .clk     (clk),
    .a_rst_i (a_rst_i),
    .i_en    (i_ready),
    .o_tick  (tick)
  );

  // Lowest enabled channel of the incoming mask, and next one above the current channel.
  always_comb begin
    first_ok = 1'b0;
    first_ch = '0;
    nxt_ok   = 1'b0;
    nxt_ch   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (i_ch_en[i]) begin
        first_ok = 1'b1;
        first_ch = CHW'(i);
      end
      if (mask[i] && (i > int'(o_acq_ch))) begin
        nxt_ok = 1'b1;
        nxt_ch = CHW'(i);
      end
    end
  end

  // The START cycle counts as the first clock of a phase.
  assign expired = (phase_cnt >= TW'(P_TIMEOUT - 1));

  // Sequencer FSM with registered pulses and counters.
  always_ff @(posedge clk or posedge a_rst_i) begin
    if (a_rst_i) begin
      state       <= ST_IDLE;
      mask        <= '0;
      phase_cnt   <= '0;
      o_acq_start <= 1'b0;
      o_acq_ch    <= '0;
      o_pkt_start <= 1'b0;
      o_tx_start  <= 1'b0;
      o_busy      <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
      o_frame_cnt <= '0;
      o_err_cnt   <= '0;
    end else begin
      o_acq_start <= 1'b0;
      o_pkt_start <= 1'b0;
      o_tx_start  <= 1'b0;
      o_timeout   <= 1'b0;
      o_overrun   <= 1'b0;
      if (!i_ready) begin
        state    <= ST_IDLE;
        mask     <= '0;
        o_acq_ch <= '0;
        o_busy   <= 1'b0;
      end else begin
        // A tick during a frame is dropped; the frame carries on.
        if (tick && state != ST_IDLE && state != ST_WAIT_TICK) o_overrun <= 1'b1;
        case (state)
          ST_IDLE: state <= ST_WAIT_TICK;
          ST_WAIT_TICK: if (tick) begin
            mask <= i_ch_en;
            if (first_ok) begin
              o_acq_ch    <= first_ch;
              o_acq_start <= 1'b1;
              o_busy      <= 1'b1;
              phase_cnt   <= '0;
              state       <= ST_ACQ_START;
            end
          end
          ST_ACQ_START, ST_PKT_START, ST_TX_START: begin
            phase_cnt <= phase_cnt + 1'b1;
            state     <= seq_state_e'(state + 3'd1);
          end
          ST_ACQ_WAIT: begin
            if (i_acq_end) begin
              phase_cnt <= '0;
              if (nxt_ok) begin
                o_acq_ch    <= nxt_ch;
                o_acq_start <= 1'b1;
                state       <= ST_ACQ_START;
              end else begin
                o_pkt_start <= 1'b1;
                state       <= ST_PKT_START;
              end
            end else if (expired) begin
              o_timeout <= 1'b1;
              o_err_cnt <= sat_inc(o_err_cnt);
              o_busy    <= 1'b0;
              state     <= ST_WAIT_TICK;
            end else phase_cnt <= phase_cnt + 1'b1;
          end
          ST_PKT_WAIT: begin
            if (i_pkt_end) begin
              phase_cnt  <= '0;
              o_tx_start <= 1'b1;
              state      <= ST_TX_START;
            end else if (expired) begin
              o_timeout <= 1'b1;
              o_err_cnt <= sat_inc(o_err_cnt);
              o_busy    <= 1'b0;
              state     <= ST_WAIT_TICK;
            end else phase_cnt <= phase_cnt + 1'b1;
          end
          ST_TX_WAIT: begin
            if (i_tx_end) begin
              o_frame_cnt <= o_frame_cnt + 1'b1;
              o_busy      <= 1'b0;
              state       <= ST_WAIT_TICK;
            end else if (expired) begin
              o_timeout <= 1'b1;
              o_err_cnt <= sat_inc(o_err_cnt);
              o_busy    <= 1'b0;
              state     <= ST_WAIT_TICK;
            end else phase_cnt <= phase_cnt + 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule
